// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the two-port cache access arbiter.
package cache_arb_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_WAIT = 3'd2,
        FILL     = 3'd3,
        RESP     = 3'd4
    } arb_state_t;

endpackage

// File: rtl/cache_access_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port
// that was not served last. The caller owns the last_served register.
import cache_arb_pkg::*;

module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last_served,
    output logic [1:0] o_grant
);

    // Combinational one-hot winner selection
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_last_served == 1'b1) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/cache_access_arbiter.sv
// Shares one direct-mapped cache and its backing memory between two
// requesters. One transaction in flight; lookup, refill and response are
// sequenced here, with saturating hit/miss statistics.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  IDLE     | no owner; arbitrate among pending requests
//  LOOKUP   | cache probed with the latched address; hit/miss sampled
//  MEM_WAIT | miss: memory read held until mem_ready
//  FILL     | one-cycle refill strobe to the cache
//  RESP     | one-cycle response pulse to the owning port
import cache_arb_pkg::*;

module cache_access_arbiter #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [1:0]        grant,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_miss,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              cache_write,
    output logic              mem_read,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_word,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [1:0]        r_grant;
    logic              r_last_served;
    logic [ADDR_W-1:0] r_cache_addr;
    logic [DATA_W-1:0] r_resp_data;
    logic [CNT_W-1:0]  r_hit_count;
    logic [CNT_W-1:0]  r_miss_count;

    logic [1:0]        w_pick;
    logic              w_start;
    logic              w_hit;
    logic              w_miss;
    logic              w_fill_take;

    rr_pick2 u_pick (
        .i_req         (req),
        .i_last_served (r_last_served),
        .o_grant       (w_pick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state datapath enables
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        w_fill_take = 1'b0;
        case (r_state)
            IDLE: begin
                if (req != 2'b00) begin
                    w_start     = 1'b1;
                    w_state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cache_miss) begin
                    w_miss      = 1'b1;
                    w_state_nxt = MEM_WAIT;
                end else begin
                    w_hit       = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    w_fill_take = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            FILL:    w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Ownership, latched address and round-robin history
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant       <= 2'b00;
            r_cache_addr  <= '0;
            r_last_served <= 1'b1;
        end else if (w_start) begin
            r_grant       <= w_pick;
            r_cache_addr  <= w_pick[PORT1] ? req_addr1 : req_addr0;
            r_last_served <= w_pick[PORT1];
        end else if (r_state == RESP) begin
            r_grant <= 2'b00;
        end
    end

    // Response word: cache data on a hit, memory word on a refill
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_resp_data <= '0;
        end else if (w_hit) begin
            r_resp_data <= cache_rdata;
        end else if (w_fill_take) begin
            r_resp_data <= mem_word;
        end
    end

    // Saturating statistics; hit and miss are mutually exclusive by state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + CNT_W'(1);
            end
            if (w_miss && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + CNT_W'(1);
            end
        end
    end

    assign grant       = r_grant;
    assign cache_addr  = r_cache_addr;
    assign resp_data   = r_resp_data;
    assign resp_valid  = (r_state == RESP) ? r_grant : 2'b00;
    assign mem_read    = (r_state == MEM_WAIT);
    assign cache_write = (r_state == FILL);
    assign hit_count   = r_hit_count;
    assign miss_count  = r_miss_count;

endmodule

// File: tb/tb_cache_access_arbiter.sv
// Directed bench for cache_access_arbiter: a table of single transactions
// plus hand sequences for reset, contention, reset mid-miss and saturation.
module tb_cache_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [14:0] req_addr0, req_addr1;
    logic        cache_miss;
    logic [31:0] cache_rdata;
    logic        mem_ready;
    logic [31:0] mem_word;

    logic [1:0]  resp_valid, grant;
    logic [31:0] resp_data;
    logic [14:0] cache_addr;
    logic        cache_write, mem_read;
    logic [15:0] hit_count, miss_count;

    logic [1:0]  s_resp_valid, s_grant;
    logic [31:0] s_resp_data;
    logic [14:0] s_cache_addr;
    logic        s_cache_write, s_mem_read;
    logic [3:0]  s_hit_count, s_miss_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_hit = 0;
    int exp_miss = 0;

    always #5 clk = ~clk;

    cache_access_arbiter dut (
        .clk(clk), .rst(rst), .req(req),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .resp_valid(resp_valid), .resp_data(resp_data), .grant(grant),
        .cache_addr(cache_addr), .cache_miss(cache_miss), .cache_rdata(cache_rdata),
        .cache_write(cache_write), .mem_read(mem_read), .mem_ready(mem_ready),
        .mem_word(mem_word), .hit_count(hit_count), .miss_count(miss_count)
    );

    // Narrow-counter copy on the same stimulus, so saturation is reachable quickly
    cache_access_arbiter #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .req(req),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .resp_valid(s_resp_valid), .resp_data(s_resp_data), .grant(s_grant),
        .cache_addr(s_cache_addr), .cache_miss(cache_miss), .cache_rdata(cache_rdata),
        .cache_write(s_cache_write), .mem_read(s_mem_read), .mem_ready(mem_ready),
        .mem_word(mem_word), .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    typedef struct {
        logic        port;
        logic [14:0] addr;
        logic        miss;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] mword;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_mr;
        int          exp_cw;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_counters();
        int sat_hit;
        int sat_miss;
        sat_hit  = (exp_hit  > 15) ? 15 : exp_hit;
        sat_miss = (exp_miss > 15) ? 15 : exp_miss;
        chk("hit_count",      64'(hit_count),    64'(exp_hit));
        chk("miss_count",     64'(miss_count),   64'(exp_miss));
        chk("sat_hit_count",  64'(s_hit_count),  64'(sat_hit));
        chk("sat_miss_count", 64'(s_miss_count), 64'(sat_miss));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = 2'b00;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_hit = 0;
        exp_miss = 0;
    endtask

    // Issue one request at cycle 0 and follow it to its response
    task automatic run_vec(input vec_t v);
        int lat;
        int mr;
        int cw;
        lat = -1;
        mr = 0;
        cw = 0;
        @(negedge clk);
        req = 2'b00;
        req[v.port] = 1'b1;
        req_addr0 = v.port ? ~v.addr : v.addr;
        req_addr1 = v.port ? v.addr : ~v.addr;
        cache_miss = v.miss;
        cache_rdata = v.rdata;
        mem_word = v.mword;
        mem_ready = (v.delay == 0);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("grant", 64'(grant), v.port ? 64'd2 : 64'd1);
                chk("cache_addr", 64'(cache_addr), 64'(v.addr));
            end
            if (mem_read) mr++;
            if (cache_write) cw++;
            if (resp_valid != 2'b00) begin
                lat = c;
                chk("resp_valid", 64'(resp_valid), v.port ? 64'd2 : 64'd1);
                chk("resp_data", 64'(resp_data), 64'(v.exp_data));
                req = 2'b00;
                break;
            end
            mem_ready = (v.delay == 0) || (c >= 2 + v.delay);
        end
        mem_ready = 1'b0;
        chk("latency", 64'(lat), 64'(v.exp_lat));
        chk("mem_read_cycles", 64'(mr), 64'(v.exp_mr));
        chk("cache_write_cycles", 64'(cw), 64'(v.exp_cw));
        if (v.miss) exp_miss++; else exp_hit++;
        @(negedge clk);
        chk("idle_grant", 64'(grant), 64'd0);
        chk("idle_resp_valid", 64'(resp_valid), 64'd0);
        chk_counters();
    endtask

    initial begin
        logic [1:0] gq[4];
        int ng;
        logic [1:0] prev_g;
        logic seen;

        vecs[0] = '{1'b0, 15'h0123, 1'b0, 32'hDEADBEEF, 0, 32'h0,        32'hDEADBEEF, 2, 0, 0};
        vecs[1] = '{1'b1, 15'h7FFE, 1'b1, 32'hBAD0BAD0, 3, 32'h12345678, 32'h12345678, 7, 4, 1};
        vecs[2] = '{1'b0, 15'h4004, 1'b1, 32'hFFFF0000, 0, 32'hA5A55A5A, 32'hA5A55A5A, 4, 1, 1};
        vecs[3] = '{1'b1, 15'h0001, 1'b0, 32'h0F0F0F0F, 0, 32'h11111111, 32'h0F0F0F0F, 2, 0, 0};
        vecs[4] = '{1'b0, 15'h7FFF, 1'b1, 32'h00000000, 1, 32'hCAFEF00D, 32'hCAFEF00D, 5, 2, 1};

        rst = 1'b0;
        req = 2'b11;
        req_addr0 = 15'h0AAA;
        req_addr1 = 15'h0555;
        cache_miss = 1'b0;
        cache_rdata = 32'h600DF00D;
        mem_ready = 1'b0;
        mem_word = 32'h0;

        // Reset held two cycles with both ports requesting
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_grant", 64'(grant), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_resp_data", 64'(resp_data), 64'd0);
            chk("rst_cache_addr", 64'(cache_addr), 64'd0);
            chk("rst_cache_write", 64'(cache_write), 64'd0);
            chk("rst_mem_read", 64'(mem_read), 64'd0);
            chk("rst_hit_count", 64'(hit_count), 64'd0);
            chk("rst_miss_count", 64'(miss_count), 64'd0);
        end

        // Contention: both ports held, all hits; port 0 first, then alternate
        rst = 1'b1;
        ng = 0;
        prev_g = 2'b00;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (grant != 2'b00 && prev_g == 2'b00 && ng < 4) begin
                gq[ng] = grant;
                ng++;
            end
            if (resp_valid != 2'b00) chk("cont_resp_data", 64'(resp_data), 64'h600DF00D);
            prev_g = grant;
        end
        chk("cont_num_grants", 64'(ng), 64'd4);
        chk("cont_grant0", 64'(gq[0]), 64'd1);
        chk("cont_grant1", 64'(gq[1]), 64'd2);
        chk("cont_grant2", 64'(gq[2]), 64'd1);
        chk("cont_grant3", 64'(gq[3]), 64'd2);

        // Single transactions from the table
        do_reset();
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset during MEM_WAIT drops the transaction silently
        do_reset();
        @(negedge clk);
        req = 2'b01;
        req_addr0 = 15'h1234;
        cache_miss = 1'b1;
        mem_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = mem_read;
        end
        chk("midmiss_reached_mem_wait", 64'(seen), 64'd1);
        rst = 1'b0;
        req = 2'b00;
        @(negedge clk);
        chk("midmiss_grant", 64'(grant), 64'd0);
        chk("midmiss_mem_read", 64'(mem_read), 64'd0);
        chk("midmiss_resp_valid", 64'(resp_valid), 64'd0);
        chk("midmiss_cache_write", 64'(cache_write), 64'd0);
        chk("midmiss_miss_count", 64'(miss_count), 64'd0);
        chk("midmiss_hit_count", 64'(hit_count), 64'd0);
        rst = 1'b1;
        mem_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid != 2'b00 || mem_read) seen = 1'b1;
        end
        chk("midmiss_quiet_after", 64'(seen), 64'd0);
        mem_ready = 1'b0;

        // Saturation: one miss, then enough hits to pin the narrow counter
        do_reset();
        run_vec(vecs[2]);
        for (int i = 0; i < 20; i++) run_vec(vecs[0]);
        chk("sat_hit_pinned", 64'(s_hit_count), 64'hF);
        chk("sat_miss_unchanged", 64'(s_miss_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
